// File: rtl/coolgirl_pkg.sv
// Shared multicart definitions: famiclone detector state encoding and
// synchroniser / settle depths.
package coolgirl_pkg;

    typedef enum logic [1:0] {
        INIT,
        SETTLE,
        SAMPLE,
        DONE
    } fcd_state_t;

    localparam int unsigned FCD_SYNC_STAGES   = 2;
    localparam int unsigned FCD_SETTLE_CYCLES = 2;

endpackage

// File: rtl/famiclone_detector_sync2.sv
// sync2: parametrised-width multi-flop synchroniser for asynchronous PPU pins.
module sync2
    import coolgirl_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [FCD_SYNC_STAGES];

    // Shift the raw pin levels through the synchroniser chain.
    always_ff @(posedge clk) begin
        stage_q[0] <= d;
        for (int unsigned i = 1; i < FCD_SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[FCD_SYNC_STAGES-1];

endmodule

// File: rtl/famiclone_detector.sv
// famiclone_detector: power-on detection of new famiclones that drive PPU /A13
// inconsistently with A13. Grounds CIRAM /CE and /A13 during INIT, then
// samples qualified PPU reads and latches a verdict.
// Optional feature macro: FAMICLONE_DETECT_REARM_EN (rearm in DONE restarts).
module famiclone_detector
    import coolgirl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES     = 15,
    parameter int unsigned SAMPLES_LO      = 3,
    parameter int unsigned SAMPLES_HI      = 3,
    parameter int unsigned MISMATCH_THRESH = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic m2,
    input  logic rst,
    input  logic ppu_rd_in,
    input  logic ppu_a13_in,
    input  logic ppu_not_a13_in,
    input  logic rearm,
    output logic hold_low,
    output logic done,
    output logic new_dendy,
    output logic timed_out
);

    localparam int unsigned INIT_W   = $clog2(INIT_CYCLES + 1);
    localparam int unsigned SETTLE_W = $clog2(FCD_SETTLE_CYCLES + 1);
    localparam int unsigned LO_W     = $clog2(SAMPLES_LO + 1);
    localparam int unsigned HI_W     = $clog2(SAMPLES_HI + 1);
    localparam int unsigned MIS_W    = $clog2(MISMATCH_THRESH + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INIT_W-1:0]   INIT_LOAD   = INIT_W'(INIT_CYCLES);
    localparam logic [INIT_W-1:0]   INIT_ONE    = INIT_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(FCD_SETTLE_CYCLES - 1);
    localparam logic [LO_W-1:0]     LO_MAX      = LO_W'(SAMPLES_LO);
    localparam logic [HI_W-1:0]     HI_MAX      = HI_W'(SAMPLES_HI);
    localparam logic [MIS_W-1:0]    MIS_MAX     = MIS_W'(MISMATCH_THRESH);
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

    fcd_state_t          state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [LO_W-1:0]     lo_cnt_q, lo_cnt_d;
    logic [HI_W-1:0]     hi_cnt_q, hi_cnt_d;
    logic [MIS_W-1:0]    mis_run_q, mis_run_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                done_q, done_d;
    logic                new_dendy_q, new_dendy_d;
    logic                timed_out_q, timed_out_d;
    logic                rd_prev_q, rd_prev_d;

    logic [2:0] sync_w;
    logic       rd_s, a13_s, not_a13_s, qual_rd;

    sync2 #(.WIDTH(3)) u_sync (
        .clk (m2),
        .d   ({ppu_rd_in, ppu_a13_in, ppu_not_a13_in}),
        .q   (sync_w)
    );

    assign rd_s      = sync_w[2];
    assign a13_s     = sync_w[1];
    assign not_a13_s = sync_w[0];
    assign qual_rd   = !rd_s && !rd_prev_q;

`ifndef FAMICLONE_DETECT_REARM_EN
    logic unused_rearm;
    assign unused_rearm = rearm;
`endif

    // Next-state, counter and verdict logic for the detection sequence.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        settle_cnt_d = settle_cnt_q;
        lo_cnt_d     = lo_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        mis_run_d    = mis_run_q;
        to_cnt_d     = to_cnt_q;
        done_d       = done_q;
        new_dendy_d  = new_dendy_q;
        timed_out_d  = timed_out_q;
        rd_prev_d    = rd_s;

        unique case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q - 1'b1;
                if (init_cnt_q == INIT_ONE) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d  = SAMPLE;
                    lo_cnt_d = '0;
                    hi_cnt_d = '0;
                    mis_run_d = '0;
                    to_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (qual_rd) begin
                    if (!a13_s && lo_cnt_q != LO_MAX) lo_cnt_d = lo_cnt_q + 1'b1;
                    if (a13_s && hi_cnt_q != HI_MAX)  hi_cnt_d = hi_cnt_q + 1'b1;
                    if (not_a13_s == a13_s) begin
                        if (mis_run_q != MIS_MAX) mis_run_d = mis_run_q + 1'b1;
                    end else begin
                        mis_run_d = '0;
                    end
                end
                // Decisions use this cycle's updated counts so a verdict lands
                // on the same edge as the deciding read.
                if (mis_run_d == MIS_MAX) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    new_dendy_d = 1'b1;
                end else if (lo_cnt_d == LO_MAX && hi_cnt_d == HI_MAX) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    new_dendy_d = 1'b0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    new_dendy_d = 1'b0;
                    timed_out_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            DONE: begin
`ifdef FAMICLONE_DETECT_REARM_EN
                if (rearm) begin
                    state_d      = INIT;
                    init_cnt_d   = INIT_LOAD;
                    settle_cnt_d = '0;
                    lo_cnt_d     = '0;
                    hi_cnt_d     = '0;
                    mis_run_d    = '0;
                    to_cnt_d     = '0;
                    done_d       = 1'b0;
                    new_dendy_d  = 1'b0;
                    timed_out_d  = 1'b0;
                end
`endif
            end
        endcase
    end

    // State and counter registers with synchronous active-high reset.
    always_ff @(posedge m2) begin
        if (rst) begin
            state_q      <= INIT;
            init_cnt_q   <= INIT_LOAD;
            settle_cnt_q <= '0;
            lo_cnt_q     <= '0;
            hi_cnt_q     <= '0;
            mis_run_q    <= '0;
            to_cnt_q     <= '0;
            done_q       <= 1'b0;
            new_dendy_q  <= 1'b0;
            timed_out_q  <= 1'b0;
            rd_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            mis_run_q    <= mis_run_d;
            to_cnt_q     <= to_cnt_d;
            done_q       <= done_d;
            new_dendy_q  <= new_dendy_d;
            timed_out_q  <= timed_out_d;
            rd_prev_q    <= rd_prev_d;
        end
    end

    assign hold_low  = (state_q == INIT);
    assign done      = done_q;
    assign new_dendy = new_dendy_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_famiclone_detector.sv
// Self-checking bench for famiclone_detector: default-parameter instance plus a
// MISMATCH_THRESH=3 instance sharing the same pins. Verdicts are checked via a
// scoreboard queue filled when a scenario's stimulus is driven.
module tb_famiclone_detector;

    logic m2 = 1'b0;
    logic rst = 1'b1;
    logic rd = 1'b1;
    logic a13 = 1'b0;
    logic na13 = 1'b1;
    logic rearm = 1'b0;

    logic hold_low, done, new_dendy, timed_out;
    logic hold_low3, done3, new_dendy3, timed_out3;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string name;
        logic  nd;
        logic  to;
    } exp_t;
    exp_t sb[$];

    always #5 m2 = ~m2;

    famiclone_detector dut (
        .m2(m2), .rst(rst), .ppu_rd_in(rd), .ppu_a13_in(a13),
        .ppu_not_a13_in(na13), .rearm(rearm),
        .hold_low(hold_low), .done(done), .new_dendy(new_dendy), .timed_out(timed_out)
    );

    famiclone_detector #(.MISMATCH_THRESH(3)) dut3 (
        .m2(m2), .rst(rst), .ppu_rd_in(rd), .ppu_a13_in(a13),
        .ppu_not_a13_in(na13), .rearm(rearm),
        .hold_low(hold_low3), .done(done3), .new_dendy(new_dendy3), .timed_out(timed_out3)
    );

    // Reset, release, and run through INIT (15) + SETTLE (2) with /RD idle.
    task automatic start_run();
        rst = 1'b1; rd = 1'b1; a13 = 1'b0; na13 = 1'b1; rearm = 1'b0;
        repeat (2) @(negedge m2);
        rst = 1'b0;
        repeat (17) @(negedge m2);
    endtask

    // One cycle of /RD low with the given A13 and /A13 pin levels.
    task automatic rd_cycle(input logic a, input logic n);
        rd = 1'b0; a13 = a; na13 = n;
        @(negedge m2);
    endtask

    task automatic wait_done(input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen = 1'b0;
        while (cycles < limit && !seen) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge m2);
                cycles++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rd = 1'b1;
        repeat (2) @(negedge m2);
        checks++;
        if ({hold_low, done, new_dendy, timed_out} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_values: got %b required 1000", {hold_low, done, new_dendy, timed_out});
        end
        rst = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge m2);
            checks++;
            if (hold_low !== (i < 15)) begin
                failures++;
                $display("FAIL hold_low_edge%0d: got %b required %b", i, hold_low, (i < 15));
            end
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_early_edge%0d: got %b required 0", i, done);
            end
        end
    endtask

    task automatic test_standard();
        int  cyc;
        bit  seen;
        exp_t e;
        start_run();
        sb.push_back('{"standard", 1'b0, 1'b0});
        rd_cycle(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) rd_cycle(i[0], !i[0]);
        rd = 1'b1;
        wait_done(20, cyc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done: got 0 required 1 within 20 cycles", e.name);
        end
        checks++;
        if ({new_dendy, timed_out} !== {e.nd, e.to}) begin
            failures++;
            $display("FAIL %s_verdict: got nd=%b to=%b required nd=%b to=%b", e.name, new_dendy, timed_out, e.nd, e.to);
        end
    endtask

    task automatic test_new_famiclone();
        int  cyc;
        bit  seen;
        exp_t e;
        start_run();
        sb.push_back('{"new_famiclone", 1'b1, 1'b0});
        rd_cycle(1'b0, 1'b1);
        rd_cycle(1'b0, 1'b0);
        rd_cycle(1'b1, 1'b1);
        rd = 1'b1;
        wait_done(20, cyc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done: got 0 required 1 within 20 cycles", e.name);
        end
        checks++;
        if ({new_dendy, timed_out} !== {e.nd, e.to}) begin
            failures++;
            $display("FAIL %s_verdict: got nd=%b to=%b required nd=%b to=%b", e.name, new_dendy, timed_out, e.nd, e.to);
        end
        checks++;
        if (done3 !== 1'b0) begin
            failures++;
            $display("FAIL thresh3_two_mismatches: got done=%b required 0", done3);
        end
    endtask

    task automatic test_glitch();
        int  cyc;
        bit  seen;
        exp_t e;
        start_run();
        sb.push_back('{"glitch", 1'b0, 1'b0});
        rd_cycle(1'b0, 1'b1);
        rd_cycle(1'b1, 1'b1);
        rd_cycle(1'b0, 1'b1);
        rd_cycle(1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) rd_cycle(i[0], !i[0]);
        rd = 1'b1;
        wait_done(20, cyc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done: got 0 required 1 within 20 cycles", e.name);
        end
        checks++;
        if ({new_dendy, timed_out} !== {e.nd, e.to}) begin
            failures++;
            $display("FAIL %s_verdict: got nd=%b to=%b required nd=%b to=%b", e.name, new_dendy, timed_out, e.nd, e.to);
        end
    endtask

    task automatic test_timeout();
        int  cyc;
        bit  seen;
        exp_t e;
        start_run();
        sb.push_back('{"timeout", 1'b0, 1'b1});
        wait_done(5000, cyc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || cyc != 4096) begin
            failures++;
            $display("FAIL %s_latency: got seen=%b cycles=%0d required seen=1 cycles=4096", e.name, seen, cyc);
        end
        checks++;
        if ({new_dendy, timed_out} !== {e.nd, e.to}) begin
            failures++;
            $display("FAIL %s_verdict: got nd=%b to=%b required nd=%b to=%b", e.name, new_dendy, timed_out, e.nd, e.to);
        end
    endtask

    task automatic test_rst_mid_sample();
        bit seen;
        start_run();
        rd_cycle(1'b0, 1'b1);
        rd_cycle(1'b0, 1'b0);
        rd_cycle(1'b0, 1'b0);
        rd = 1'b1;
        repeat (3) @(negedge m2);
        checks++;
        if (done3 !== 1'b0) begin
            failures++;
            $display("FAIL mid_sample_pre_rst: got done=%b required 0", done3);
        end
        rst = 1'b1;
        @(negedge m2);
        checks++;
        if ({hold_low3, done3, new_dendy3, timed_out3} !== 4'b1000) begin
            failures++;
            $display("FAIL mid_sample_rst: got %b required 1000", {hold_low3, done3, new_dendy3, timed_out3});
        end
        rst = 1'b0;
        repeat (17) @(negedge m2);
        rd_cycle(1'b0, 1'b1);
        rd_cycle(1'b0, 1'b0);
        rd = 1'b1;
        repeat (4) @(negedge m2);
        checks++;
        if ({hold_low3, done3} !== 2'b00) begin
            failures++;
            $display("FAIL mis_run_cleared: got hold=%b done=%b required hold=0 done=0", hold_low3, done3);
        end
        rd_cycle(1'b0, 1'b1);
        rd_cycle(1'b1, 1'b1);
        rd_cycle(1'b0, 1'b0);
        rd = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (done3) seen = 1'b1;
            else @(negedge m2);
        end
        checks++;
        if ({seen, new_dendy3} !== 2'b11) begin
            failures++;
            $display("FAIL thresh3_third_mismatch: got done=%b nd=%b required done=1 nd=1", seen, new_dendy3);
        end
    endtask

    task automatic test_rearm();
        int  cyc;
        bit  seen;
        start_run();
        rd_cycle(1'b0, 1'b1);
        rd_cycle(1'b0, 1'b0);
        rd_cycle(1'b0, 1'b0);
        rd = 1'b1;
        wait_done(20, cyc, seen);
        checks++;
        if ({seen, new_dendy} !== 2'b11) begin
            failures++;
            $display("FAIL rearm_setup: got done=%b nd=%b required done=1 nd=1", seen, new_dendy);
        end
        rearm = 1'b1;
        @(negedge m2);
        rearm = 1'b0;
`ifdef FAMICLONE_DETECT_REARM_EN
        checks++;
        if ({hold_low, done, new_dendy, timed_out} !== 4'b1000) begin
            failures++;
            $display("FAIL rearm_restart: got %b required 1000", {hold_low, done, new_dendy, timed_out});
        end
        for (int i = 1; i <= 15; i++) begin
            @(negedge m2);
            checks++;
            if (hold_low !== (i < 15)) begin
                failures++;
                $display("FAIL rearm_hold_edge%0d: got %b required %b", i, hold_low, (i < 15));
            end
        end
        repeat (2) @(negedge m2);
        begin
            exp_t e;
            sb.push_back('{"rearm_standard", 1'b0, 1'b0});
            rd_cycle(1'b0, 1'b1);
            for (int i = 0; i < 6; i++) rd_cycle(i[0], !i[0]);
            rd = 1'b1;
            wait_done(20, cyc, seen);
            e = sb.pop_front();
            checks++;
            if (!seen || {new_dendy, timed_out} !== {e.nd, e.to}) begin
                failures++;
                $display("FAIL %s_verdict: got done=%b nd=%b to=%b required done=1 nd=%b to=%b",
                         e.name, seen, new_dendy, timed_out, e.nd, e.to);
            end
        end
`else
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({hold_low, done, new_dendy, timed_out} !== 4'b0110) begin
                failures++;
                $display("FAIL rearm_ignored_cycle%0d: got %b required 0110", i, {hold_low, done, new_dendy, timed_out});
            end
            @(negedge m2);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_standard();
        test_new_famiclone();
        test_glitch();
        test_timeout();
        test_rst_mid_sample();
        test_rearm();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drained: got %0d entries required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion required finish before 1000000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
